// File: rtl/acsi_cmd_sequencer_if.sv
// acsi_cmd_sequencer_if: bundles the hdd AVR-port signals and the CDB/status
// consumer handshake of acsi_cmd_sequencer.
//   master : sequencer side (drives a_cs/a_bus_dir/selects/a_ready/a_data_out,
//            cdb_*, status_done, abort)
//   slave  : environment side (hdd and CDB consumer)
interface acsi_cmd_sequencer_if;
  logic [7:0]   a_data_in;
  logic [7:0]   a_data_out;
  logic         a_int;
  logic         a_cmd;
  logic         a_cs;
  logic         a_bus_dir;
  logic         a_extra;
  logic         a_extra_2;
  logic         a_ready;
  logic         cdb_valid;
  logic         cdb_ready;
  logic [2:0]   cdb_id;
  logic [3:0]   cdb_len;
  logic [103:0] cdb_data;
  logic         status_valid;
  logic [7:0]   status_byte;
  logic         status_done;
  logic         abort;

  modport master (
    input  a_data_in, a_int, a_cmd, cdb_ready, status_valid, status_byte,
    output a_data_out, a_cs, a_bus_dir, a_extra, a_extra_2, a_ready,
           cdb_valid, cdb_id, cdb_len, cdb_data, status_done, abort
  );

  modport slave (
    output a_data_in, a_int, a_cmd, cdb_ready, status_valid, status_byte,
    input  a_data_out, a_cs, a_bus_dir, a_extra, a_extra_2, a_ready,
           cdb_valid, cdb_id, cdb_len, cdb_data, status_done, abort
  );
endinterface

// File: rtl/acsi_cmd_sequencer.sv
// acsi_cmd_sequencer: stands in for the AVR on the hdd block's AVR port.
// After reset it writes the ACSI ID map and command mode, then collects
// ACSI/ICD CDBs byte by byte, presents each on a valid/ready port, returns
// the consumer's status byte to the Atari and writes the unselect command.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   bus          : acsi_cmd_sequencer_if.master (hdd port + CDB/status port)
// Outputs are decoded from registered state only; the reset state decodes to
// all-zero outputs, so a reset drops a_cs/a_bus_dir on the next clock.
module acsi_cmd_sequencer #(
  parameter logic [7:0] ACSI_IDS       = 8'h01,
  parameter int         STROBE_CYCLES  = 4,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input logic                  clock,
  input logic                  reset,
  acsi_cmd_sequencer_if.master bus
);
  localparam int CW = $clog2(2*STROBE_CYCLES+2);
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [CW-1:0] S_HI   = CW'(STROBE_CYCLES);
  localparam logic [CW-1:0] WR_HI  = CW'(STROBE_CYCLES+1);
  localparam logic [CW-1:0] WR_END = CW'(2*STROBE_CYCLES+1);
  localparam logic [CW-1:0] RD_END = CW'(2*STROBE_CYCLES-1);
  localparam logic [CW-1:0] TX_END = CW'(2*STROBE_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES-1);

  typedef enum logic [2:0] {
    CFG_IDS, CFG_MODE, IDLE, RD_STROBE, PRESENT, WAIT_STATUS, SEND_STATUS, UNSELECT
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [3:0]        idx, idx_n;
  logic [3:0]        tlen, tlen_n;
  logic              full, full_n;
  logic              ext;
  logic [2:0]        id;
  logic [12:0][7:0]  cdb_q;
  logic [7:0]        stat_q;
  logic [TW-1:0]     tmo;
  logic              take;

  function automatic logic [3:0] icd_len(input logic [2:0] grp);
    case (grp)
      3'd0:       icd_len = 4'd7;
      3'd1, 3'd2: icd_len = 4'd11;
      3'd5:       icd_len = 4'd13;
      default:    icd_len = 4'd7;
    endcase
  endfunction

  assign take = (state == IDLE) && bus.a_int;

  // Index/length update for the byte sampled in IDLE.
  always_comb begin
    idx_n  = idx;
    tlen_n = tlen;
    if (bus.a_cmd) begin
      idx_n  = 4'd1;
      tlen_n = 4'd6;
    end else if (idx != 4'd0) begin
      idx_n = idx + 4'd1;
      if (idx == 4'd1 && ext) tlen_n = icd_len(bus.a_data_in[7:5]);
    end
    // a stray data byte at index 0 must never complete a CDB
    full_n = (bus.a_cmd || idx != 4'd0) && (idx_n == tlen_n);
  end

  always_comb begin
    state_n          = state;
    cnt_n            = cnt;
    bus.a_cs         = 1'b0;
    bus.a_bus_dir    = 1'b0;
    bus.a_extra      = 1'b0;
    bus.a_extra_2    = 1'b0;
    bus.a_data_out   = 8'h00;
    bus.a_ready      = 1'b0;
    bus.cdb_valid    = 1'b0;
    bus.status_done  = 1'b0;
    bus.abort        = 1'b0;
    case (state)
      // Register writes: cnt 0 all idle, 1 setup, 2..S+1 strobe, then S low.
      CFG_IDS, CFG_MODE, UNSELECT: begin
        if (cnt != '0) begin
          bus.a_bus_dir  = 1'b1;
          bus.a_extra_2  = (state == CFG_IDS);
          bus.a_extra    = (state != CFG_IDS);
          bus.a_data_out = (state == CFG_IDS)  ? ACSI_IDS :
                           (state == CFG_MODE) ? 8'h20 : 8'h60;
        end
        bus.a_cs = (cnt >= CW'(2)) && (cnt <= WR_HI);
        if (cnt == WR_END) begin
          cnt_n           = '0;
          state_n         = (state == CFG_IDS) ? CFG_MODE : IDLE;
          bus.status_done = (state == UNSELECT);
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      IDLE: begin
        bus.a_ready = 1'b1;
        if (bus.a_int) begin
          state_n = RD_STROBE;
          cnt_n   = '0;
        end else if (idx != 4'd0 && tmo == TMO_LAST) begin
          bus.abort = 1'b1;
        end
      end
      // Read strobe: cnt 0..S-1 high, then low; hold until hdd drops a_int.
      RD_STROBE: begin
        bus.a_ready = !full;
        bus.a_cs    = (cnt < S_HI);
        if (cnt == RD_END) begin
          if (!bus.a_int) begin
            cnt_n   = '0;
            state_n = full ? PRESENT : IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PRESENT: begin
        bus.cdb_valid = 1'b1;
        if (bus.cdb_ready) state_n = WAIT_STATUS;
      end
      WAIT_STATUS: begin
        if (bus.status_valid) begin
          state_n = SEND_STATUS;
          cnt_n   = '0;
        end
      end
      // Status: data set up at cnt 0 until clear-to-send, strobe 1..S, low S.
      SEND_STATUS: begin
        bus.a_bus_dir  = 1'b1;
        bus.a_data_out = stat_q;
        bus.a_cs       = (cnt != '0) && (cnt <= S_HI);
        if (cnt == '0) begin
          if (bus.a_int) cnt_n = CW'(1);
        end else if (cnt == TX_END) begin
          cnt_n   = '0;
          state_n = UNSELECT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = CFG_IDS;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= CFG_IDS;
      cnt    <= '0;
      idx    <= 4'd0;
      tlen   <= 4'd0;
      full   <= 1'b0;
      ext    <= 1'b0;
      id     <= 3'd0;
      cdb_q  <= '0;
      stat_q <= 8'h00;
      tmo    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (take) begin
        tmo  <= '0;
        idx  <= idx_n;
        tlen <= tlen_n;
        full <= full_n;
        if (bus.a_cmd) begin
          cdb_q    <= '0;
          cdb_q[0] <= bus.a_data_in;
          id       <= bus.a_data_in[7:5];
          ext      <= (bus.a_data_in[4:0] == 5'h1F);
        end else if (idx != 4'd0) begin
          cdb_q[idx] <= bus.a_data_in;
        end
      end else if (state == IDLE && idx != 4'd0) begin
        if (tmo == TMO_LAST) begin
          idx <= 4'd0;
          tmo <= '0;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end
      if (state == PRESENT && bus.cdb_ready) begin
        idx  <= 4'd0;
        full <= 1'b0;
      end
      if (state == WAIT_STATUS && bus.status_valid) stat_q <= bus.status_byte;
    end
  end

  assign bus.cdb_id   = id;
  assign bus.cdb_len  = tlen;
  assign bus.cdb_data = cdb_q;
endmodule

// File: tb/tb_acsi_cmd_sequencer.sv
module tb_acsi_cmd_sequencer;
  localparam int S   = 4;
  localparam int TMO = 60;
  localparam logic [7:0] IDS = 8'h01;

  localparam int K_IDS = 0, K_EXT = 1, K_STAT = 2, K_CDB = 3, K_DONE = 4, K_ABORT = 5;
  localparam int W_CSRD = 0, W_CSTX = 1, W_VALID = 2, W_TX = 3, W_DONE = 4, W_ABORT = 5;

  typedef struct {
    int           kind;
    logic [2:0]   id;
    logic [3:0]   len;
    logic [103:0] data;
    logic [7:0]   b;
  } ev_t;

  logic clock, reset;
  acsi_cmd_sequencer_if bif();

  acsi_cmd_sequencer #(.ACSI_IDS(IDS), .STROBE_CYCLES(S), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .bus(bif.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  int   proto_err = 0;
  ev_t  evq[$];
  logic [7:0] cur [13];
  int   cur_len;

  function automatic string kname(input int k);
    case (k)
      K_IDS:   return "ids_write";
      K_EXT:   return "extra_write";
      K_STAT:  return "status_byte";
      K_CDB:   return "cdb";
      K_DONE:  return "status_done";
      default: return "abort";
    endcase
  endfunction

  // CDB length straight from the ACSI/ICD group rules.
  function automatic int ref_len(input logic [7:0] b0, input logic [7:0] b1);
    if (b0[4:0] != 5'h1F) return 6;
    case (b1[7:5])
      3'd0:       return 7;
      3'd1, 3'd2: return 11;
      3'd5:       return 13;
      default:    return 7;
    endcase
  endfunction

  task automatic push(input int k, input logic [2:0] id, input logic [3:0] len,
                      input logic [103:0] d, input logic [7:0] b);
    ev_t e;
    e.kind = k; e.id = id; e.len = len; e.data = d; e.b = b;
    evq.push_back(e);
  endtask

  task automatic got(input int k, input logic [2:0] id, input logic [3:0] len,
                     input logic [103:0] d, input logic [7:0] b);
    ev_t e;
    checks++;
    if (evq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got id=%0d len=%0d data=%h byte=%h required no event",
               kname(k), id, len, d, b);
    end else begin
      e = evq.pop_front();
      if (e.kind != k ||
          (k == K_CDB && (e.id != id || e.len != len || e.data != d)) ||
          ((k == K_IDS || k == K_EXT || k == K_STAT) && e.b != b)) begin
        errors++;
        $display("FAIL %s: got %s id=%0d len=%0d data=%h byte=%h required %s id=%0d len=%0d data=%h byte=%h",
                 kname(e.kind), kname(k), id, len, d, b, kname(e.kind), e.id, e.len, e.data, e.b);
      end
    end
  endtask

  // Monitor: hdd register latches, Atari status reads, CDB presentation, pulses.
  logic       p_cs, p_vld, p_dir;
  logic [7:0] p_dout;
  always @(negedge clock) begin
    if (reset) begin
      p_cs = 1'b0; p_vld = 1'b0; p_dir = 1'b0; p_dout = 8'h00;
    end else begin
      if (bif.a_cs && (p_cs || bif.a_bus_dir) &&
          (bif.a_bus_dir != p_dir || bif.a_data_out != p_dout)) begin
        proto_err++;
        errors++;
        $display("FAIL protocol: a_bus_dir=%b a_data_out=%h changed with a_cs high, required %b %h",
                 bif.a_bus_dir, bif.a_data_out, p_dir, p_dout);
      end
      if (bif.a_cs && !p_cs && bif.a_bus_dir)
        got(bif.a_extra_2 ? K_IDS : bif.a_extra ? K_EXT : K_STAT, 3'd0, 4'd0, '0, bif.a_data_out);
      if (bif.cdb_valid && !p_vld) got(K_CDB, bif.cdb_id, bif.cdb_len, bif.cdb_data, 8'h00);
      if (bif.status_done) got(K_DONE, 3'd0, 4'd0, '0, 8'h00);
      if (bif.abort) got(K_ABORT, 3'd0, 4'd0, '0, 8'h00);
      p_cs = bif.a_cs; p_vld = bif.cdb_valid; p_dir = bif.a_bus_dir; p_dout = bif.a_data_out;
    end
  end

  function automatic bit cond(input int w);
    case (w)
      W_CSRD:  return bif.a_cs && !bif.a_bus_dir;
      W_CSTX:  return bif.a_cs && bif.a_bus_dir && !bif.a_extra && !bif.a_extra_2;
      W_VALID: return bif.cdb_valid;
      W_TX:    return bif.a_bus_dir && !bif.a_extra && !bif.a_extra_2;
      W_DONE:  return bif.status_done;
      default: return bif.abort;
    endcase
  endfunction

  task automatic wait_sig(input int w, input int budget, input string nm);
    int n = 0;
    while (!cond(w) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (!cond(w)) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: waited %0d cycles, required event", nm, n);
    end
  endtask

  task automatic do_reset(input int cycles);
    int n = 0;
    evq.delete();
    reset = 1'b1;
    bif.a_int = 1'b0; bif.a_cmd = 1'b0; bif.cdb_ready = 1'b0; bif.status_valid = 1'b0;
    repeat (cycles) @(negedge clock);
    checks++;
    if (bif.a_cs !== 1'b0 || bif.a_bus_dir !== 1'b0 || bif.a_ready !== 1'b0 ||
        bif.cdb_valid !== 1'b0 || bif.a_extra !== 1'b0 || bif.a_extra_2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: a_cs=%b a_bus_dir=%b a_ready=%b cdb_valid=%b extra=%b extra_2=%b required all 0",
               bif.a_cs, bif.a_bus_dir, bif.a_ready, bif.cdb_valid, bif.a_extra, bif.a_extra_2);
    end
    push(K_IDS, 3'd0, 4'd0, '0, IDS);
    push(K_EXT, 3'd0, 4'd0, '0, 8'h20);
    reset = 1'b0;
    while (!bif.a_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!bif.a_ready || n > 4*S+4) begin
      errors++;
      $display("FAIL ready_after_reset: %0d clocks, required <= %0d", n, 4*S+4);
    end
    checks++;
    if (bif.cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_cdb_after_config: cdb_valid=%b required 0", bif.cdb_valid);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic cmd);
    @(negedge clock);
    bif.a_data_in = b; bif.a_cmd = cmd; bif.a_int = 1'b1;
    wait_sig(W_CSRD, 500, "read_strobe");
    repeat (2) @(negedge clock);
    bif.a_int = 1'b0; bif.a_cmd = 1'b0;
    repeat (2*S) @(negedge clock);
  endtask

  task automatic gen_cdb();
    for (int i = 0; i < 13; i++) cur[i] = 8'($urandom);
    if ($urandom_range(0, 1) == 1) cur[0][4:0] = 5'h1F;
    cur_len = ref_len(cur[0], cur[1]);
  endtask

  task automatic send_cdb();
    logic [103:0] d = '0;
    for (int i = 0; i < cur_len; i++) d[i*8 +: 8] = cur[i];
    push(K_CDB, cur[0][7:5], 4'(cur_len), d, 8'h00);
    for (int i = 0; i < cur_len; i++) send_byte(cur[i], i == 0);
  endtask

  task automatic txn(input logic [7:0] st, input int hold, input bit rst_mid);
    wait_sig(W_VALID, 500, "cdb_valid");
    repeat (hold) begin
      @(negedge clock);
      checks++;
      if (bif.a_ready !== 1'b0 || bif.cdb_valid !== 1'b1) begin
        errors++;
        $display("FAIL cdb_hold: a_ready=%b cdb_valid=%b required 0 1", bif.a_ready, bif.cdb_valid);
      end
    end
    bif.cdb_ready = 1'b1;
    @(negedge clock);
    bif.cdb_ready = 1'b0;
    checks++;
    if (bif.cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL cdb_accept: cdb_valid=%b required 0", bif.cdb_valid);
    end
    repeat ($urandom_range(0, 4)) @(negedge clock);
    push(K_STAT, 3'd0, 4'd0, '0, st);
    push(K_EXT, 3'd0, 4'd0, '0, 8'h60);
    push(K_DONE, 3'd0, 4'd0, '0, 8'h00);
    bif.status_byte = st; bif.status_valid = 1'b1;
    @(negedge clock);
    bif.status_valid = 1'b0;
    wait_sig(W_TX, 100, "status_setup");
    repeat ($urandom_range(0, 3)) @(negedge clock);
    bif.a_int = 1'b1;
    wait_sig(W_CSTX, 100, "status_strobe");
    if (rst_mid) begin
      @(negedge clock);
      do_reset(1);
    end else begin
      repeat (2) @(negedge clock);
      bif.a_int = 1'b0;
      wait_sig(W_DONE, 200, "status_done");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bif.a_data_in = 8'h00; bif.a_int = 1'b0; bif.a_cmd = 1'b0;
    bif.cdb_ready = 1'b0; bif.status_valid = 1'b0; bif.status_byte = 8'h00;
    repeat (3) @(negedge clock);
    do_reset(2);

    // plain 6-byte CDB for ID 0
    cur[0] = 8'h08; cur[1] = 8'h00; cur[2] = 8'h00; cur[3] = 8'h00; cur[4] = 8'h01; cur[5] = 8'h00;
    cur_len = ref_len(cur[0], cur[1]);
    send_cdb();
    checks++;
    if (bif.cdb_data[47:0] !== 48'h000100000008 || bif.cdb_len !== 4'd6) begin
      errors++;
      $display("FAIL cdb6_direct: data=%h len=%0d required 000100000008 6", bif.cdb_data[47:0], bif.cdb_len);
    end
    txn(8'h02, 3, 1'b0);

    // ICD extended, group 1 -> 11 bytes
    cur[0] = 8'h1F; cur[1] = 8'h25;
    for (int i = 2; i < 13; i++) cur[i] = 8'h00;
    cur_len = ref_len(cur[0], cur[1]);
    send_cdb();
    checks++;
    if (bif.cdb_len !== 4'd11 || bif.cdb_data[15:8] !== 8'h25) begin
      errors++;
      $display("FAIL icd_direct: len=%0d byte1=%h required 11 25", bif.cdb_len, bif.cdb_data[15:8]);
    end
    txn(8'h00, 1, 1'b0);

    // stray data byte at index 0 is dropped
    send_byte(8'($urandom), 1'b0);
    gen_cdb(); send_cdb(); txn(8'($urandom), 0, 1'b0);

    // partial CDB then silence -> abort, then a clean CDB
    gen_cdb();
    for (int i = 0; i < 3; i++) send_byte(cur[i], i == 0);
    repeat (TMO - 20) @(negedge clock);
    push(K_ABORT, 3'd0, 4'd0, '0, 8'h00);
    wait_sig(W_ABORT, 200, "abort");
    cur[0] = 8'hA8; cur[1] = 8'h11; cur[2] = 8'h22; cur[3] = 8'h33; cur[4] = 8'h44; cur[5] = 8'h55;
    cur_len = ref_len(cur[0], cur[1]);
    send_cdb(); txn(8'h5A, 2, 1'b0);

    // restart after two bytes; consumer stalls longer than the timeout
    gen_cdb();
    for (int i = 0; i < 2; i++) send_byte(cur[i], i == 0);
    gen_cdb(); send_cdb(); txn(8'($urandom), TMO + 20, 1'b0);

    // ICD group 5 -> 13 bytes
    gen_cdb(); cur[0][4:0] = 5'h1F; cur[1][7:5] = 3'd5; cur_len = ref_len(cur[0], cur[1]);
    send_cdb(); txn(8'($urandom), 1, 1'b0);

    for (int t = 0; t < 12; t++) begin
      gen_cdb(); send_cdb(); txn(8'($urandom), $urandom_range(0, 5), 1'b0);
    end

    // reset in the middle of the status strobe, then the block must start over
    gen_cdb(); send_cdb(); txn(8'hC3, 1, 1'b1);
    gen_cdb(); send_cdb(); txn(8'h02, 2, 1'b0);

    repeat (10) @(negedge clock);
    checks++;
    if (evq.size() != 0) begin
      errors++;
      $display("FAIL pending_events: %0d left, required 0 (next %s)", evq.size(), kname(evq[0].kind));
    end
    checks++;
    if (proto_err != 0) begin
      errors++;
      $display("FAIL protocol_total: %0d violations, required 0", proto_err);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
